// File: rtl/rvmem_arb_pkg.sv
// rvmem_arb_pkg: state encodings and default widths shared by rvmem_arb, rvmem_rr2
// and the memory supervisor (rvmemspv).
package rvmem_arb_pkg;

  localparam int unsigned MemAddrWidth = 32;
  localparam int unsigned MemDataWidth = 32;

  localparam logic [2:0] StInit = 3'd0;
  localparam logic [2:0] StIdle = 3'd1;
  localparam logic [2:0] StWr   = 3'd2;
  localparam logic [2:0] StWrsp = 3'd3;
  localparam logic [2:0] StRd   = 3'd4;
  localparam logic [2:0] StRrsp = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

endpackage

// File: rtl/rvmem_rr2.sv
// rvmem_rr2: combinational 2-way round-robin picker.
//   req_i  : request vector, bit N = port N
//   last_i : port granted most recently
//   gnt_o  : one-hot grant (zero when nobody requests)
module rvmem_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    if (req_i == 2'b11) begin
      // On a tie the port not served last wins.
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/rvmem_arb.sv
// rvmem_arb: two-port arbiter / transaction sequencer in front of rvmemspv.
//   clock, reset        : clock, asynchronous active-high reset
//   pN_req/we/addr/...  : requester N (0 = fetch, 1 = load/store), held until pN_ack
//   pN_ack, pN_rdata    : one-cycle completion pulse, read data held until next read ack
//   mem_ready           : DDR3 initialisation done
//   mem_*               : single AXI-lite-style write/read channel set to memory
//   busy                : high whenever not idle
module rvmem_arb
  import rvmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MemAddrWidth,
  parameter int unsigned DATA_WIDTH = MemDataWidth,
  parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [MASK_WIDTH-1:0] p0_wmask,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [MASK_WIDTH-1:0] p1_wmask,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  input  logic                  mem_ready,
  output logic                  mem_waen,
  output logic                  mem_wden,
  output logic                  mem_raen,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  input  logic                  mem_wardy,
  input  logic                  mem_wdrdy,
  input  logic                  mem_rardy,
  input  logic                  mem_wbvld,
  input  logic                  mem_rdrdy,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  logic [2:0]            st_q, st_d;
  logic                  last_q, last_d, port_q, port_d;
  logic                  waen_q, waen_d, wden_q, wden_d, raen_q, raen_d, rden_q, rden_d;
  logic                  wa_done_q, wa_done_d, wd_done_q, wd_done_d;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [1:0]            gnt;
  logic                  grant, gnt_we, wa_hs, wd_hs;

  rvmem_rr2 u_rr2 (
    .req_i  ({p1_req, p0_req}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign grant  = (st_q == StIdle) & mem_ready & (|gnt);
  assign gnt_we = gnt[1] ? p1_we : p0_we;
  assign wa_hs  = waen_q & mem_wardy;
  assign wd_hs  = wden_q & mem_wdrdy;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q <= StInit;
    end else begin
      st_q <= st_d;
    end
  end

  // Next state
  always_comb begin
    st_d = st_q;
    case (st_q)
      StInit: if (mem_ready) st_d = StIdle;
      StIdle: begin
        if (!mem_ready) st_d = StInit;
        else if (grant) st_d = gnt_we ? StWr : StRd;
      end
      // Address and data handshakes may land in either order or together.
      StWr:   if ((wa_done_q | wa_hs) & (wd_done_q | wd_hs)) st_d = StWrsp;
      StWrsp: if (mem_wbvld) st_d = StDone;
      StRd:   if (raen_q & mem_rardy) st_d = StRrsp;
      StRrsp: if (mem_rdrdy) st_d = StDone;
      StDone: st_d = StIdle;
      default: st_d = StInit;
    endcase
  end

  // Next values of the registered outputs and transaction fields
  always_comb begin
    last_d    = last_q;
    port_d    = port_q;
    waen_d    = waen_q;
    wden_d    = wden_q;
    raen_d    = raen_q;
    rden_d    = rden_q;
    wa_done_d = wa_done_q;
    wd_done_d = wd_done_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    case (st_q)
      StIdle: begin
        if (grant) begin
          port_d = gnt[1];
          if (gnt_we) begin
            waen_d    = 1'b1;
            wden_d    = 1'b1;
            wa_done_d = 1'b0;
            wd_done_d = 1'b0;
            waddr_d   = gnt[1] ? p1_addr : p0_addr;
            wdata_d   = gnt[1] ? p1_wdata : p0_wdata;
            wmask_d   = gnt[1] ? p1_wmask : p0_wmask;
          end else begin
            raen_d  = 1'b1;
            raddr_d = gnt[1] ? p1_addr : p0_addr;
          end
        end
      end
      StWr: begin
        if (wa_hs) begin
          waen_d    = 1'b0;
          wa_done_d = 1'b1;
        end
        if (wd_hs) begin
          wden_d    = 1'b0;
          wd_done_d = 1'b1;
        end
      end
      StRd: begin
        if (raen_q & mem_rardy) begin
          raen_d = 1'b0;
          rden_d = 1'b1;
        end
      end
      StRrsp: begin
        if (mem_rdrdy) begin
          rden_d = 1'b0;
          if (port_q) rdata1_d = mem_rdata;
          else        rdata0_d = mem_rdata;
        end
      end
      StDone: last_d = port_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      port_q    <= 1'b0;
      waen_q    <= 1'b0;
      wden_q    <= 1'b0;
      raen_q    <= 1'b0;
      rden_q    <= 1'b0;
      wa_done_q <= 1'b0;
      wd_done_q <= 1'b0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      last_q    <= last_d;
      port_q    <= port_d;
      waen_q    <= waen_d;
      wden_q    <= wden_d;
      raen_q    <= raen_d;
      rden_q    <= rden_d;
      wa_done_q <= wa_done_d;
      wd_done_q <= wd_done_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      // Tracks the state register, but reads 0 while reset is applied.
      busy_q    <= (st_d != StIdle);
    end
  end

  // Outputs
  assign p0_ack    = (st_q == StDone) & ~port_q;
  assign p1_ack    = (st_q == StDone) & port_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign mem_waen  = waen_q;
  assign mem_wden  = wden_q;
  assign mem_raen  = raen_q;
  assign mem_rden  = rden_q;
  assign mem_waddr = waddr_q;
  assign mem_raddr = raddr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rvmem_arb.sv
module tb_rvmem_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, p0_rdata, p1_rdata;
  logic [3:0]  p0_wmask, p1_wmask, mem_wmask;
  logic        p0_ack, p1_ack, mem_ready, busy;
  logic        mem_waen, mem_wden, mem_raen, mem_rden;
  logic [31:0] mem_waddr, mem_raddr, mem_wdata, mem_rdata;
  logic        mem_wardy, mem_wdrdy, mem_rardy, mem_wbvld, mem_rdrdy;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd0 = 32'h0;
  logic [31:0] exp_rd1 = 32'h0;

  rvmem_arb dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wmask(p0_wmask), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wmask(p1_wmask), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_ready(mem_ready), .mem_waen(mem_waen), .mem_wden(mem_wden),
    .mem_raen(mem_raen), .mem_rden(mem_rden), .mem_waddr(mem_waddr),
    .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wardy(mem_wardy), .mem_wdrdy(mem_wdrdy), .mem_rardy(mem_rardy),
    .mem_wbvld(mem_wbvld), .mem_rdrdy(mem_rdrdy), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle; values are sampled/driven 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_raen(output bit ok);
    int n = 0;
    while (!mem_raen && n < 20) begin
      tick();
      n++;
    end
    ok = mem_raen;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({mem_waen, mem_wden, mem_raen, mem_rden, p0_ack, p1_ack, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {mem_waen, mem_wden, mem_raen, mem_rden, p0_ack, p1_ack, busy});
    end
    checks++;
    if ({mem_waddr, mem_raddr, mem_wdata, mem_wmask, p0_rdata, p1_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h %h %h %h %h %h required all 0",
               mem_waddr, mem_raddr, mem_wdata, mem_wmask, p0_rdata, p1_rdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL init_busy: got %b required 1", busy);
    end
  endtask

  task automatic test_mem_ready();
    // Still in INIT: the request must wait for mem_ready.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (mem_raen !== 1'b0) begin
        failures++;
        $display("FAIL init_hold cyc%0d: raen got %b required 0", i, mem_raen);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      mem_ready = 1'b1;
      tick();
      checks++;
      if (mem_raen !== 1'b0) begin
        failures++;
        $display("FAIL ready_lat1 pass%0d: raen got %b required 0", pass, mem_raen);
      end
      tick();
      checks++;
      if (mem_raen !== 1'b1 || mem_raddr !== p0_addr) begin
        failures++;
        $display("FAIL ready_lat2 pass%0d: raen/raddr got %b/%h required 1/%h",
                 pass, mem_raen, mem_raddr, p0_addr);
      end
      mem_rardy = 1'b1;
      tick();
      mem_rardy = 1'b0;
      mem_rdrdy = 1'b1; mem_rdata = 32'hA5A5_0001 + pass;
      tick();
      mem_rdrdy = 1'b0;
      exp_rd0 = 32'hA5A5_0001 + pass;
      checks++;
      if (p0_ack !== 1'b1 || p0_rdata !== exp_rd0) begin
        failures++;
        $display("FAIL ready_read pass%0d: ack/rdata got %b/%h required 1/%h",
                 pass, p0_ack, p0_rdata, exp_rd0);
      end
      p0_req = 1'b0;
      tick();
      if (pass == 0) begin
        // Back in IDLE: drop mem_ready together with a new request.
        mem_ready = 1'b0;
        p0_req = 1'b1; p0_addr = 32'h44;
        for (int i = 0; i < 4; i++) begin
          tick();
          checks++;
          if (mem_raen !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ready_drop cyc%0d: raen/busy got %b/%b required 0/1",
                     i, mem_raen, busy);
          end
        end
      end
    end
  endtask

  task automatic test_write_split();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h100; p1_wdata = 32'hDEADBEEF; p1_wmask = 4'hF;
    tick();
    checks++;
    if ({mem_waen, mem_wden} !== 2'b11 || mem_waddr !== 32'h100 ||
        mem_wdata !== 32'hDEADBEEF || mem_wmask !== 4'hF) begin
      failures++;
      $display("FAIL wr_issue: got %b %h %h %h required 11 100 deadbeef f",
               {mem_waen, mem_wden}, mem_waddr, mem_wdata, mem_wmask);
    end
    mem_wdrdy = 1'b1;
    tick();
    mem_wdrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_waen, mem_wden} !== 2'b10) begin
        failures++;
        $display("FAIL wr_data_drop cyc%0d: waen,wden got %b required 10", i,
                 {mem_waen, mem_wden});
      end
      if (i < 2) tick();
    end
    mem_wardy = 1'b1;
    tick();
    mem_wardy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mem_waen, mem_wden, p0_ack, p1_ack, busy} !== 5'b00001) begin
        failures++;
        $display("FAIL wr_wait cyc%0d: got %b required 00001", i,
                 {mem_waen, mem_wden, p0_ack, p1_ack, busy});
      end
      if (i == 0) tick();
    end
    mem_wbvld = 1'b1;
    tick();
    mem_wbvld = 1'b0;
    checks++;
    if ({p1_ack, p0_ack} !== 2'b10) begin
      failures++;
      $display("FAIL wr_ack: p1,p0 ack got %b required 10", {p1_ack, p0_ack});
    end
    p1_req = 1'b0;
    tick();
    checks++;
    if ({p1_ack, p0_ack, busy} !== 3'b000) begin
      failures++;
      $display("FAIL wr_single_ack: ack/busy got %b required 000", {p1_ack, p0_ack, busy});
    end
  endtask

  task automatic test_read_p1();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h200;
    tick();
    checks++;
    if (mem_raen !== 1'b1 || mem_raddr !== 32'h200) begin
      failures++;
      $display("FAIL rd_issue: raen/raddr got %b/%h required 1/200", mem_raen, mem_raddr);
    end
    mem_rardy = 1'b1;
    tick();
    mem_rardy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_raen, mem_rden, p1_ack} !== 3'b010) begin
        failures++;
        $display("FAIL rd_wait cyc%0d: raen,rden,ack got %b required 010", i,
                 {mem_raen, mem_rden, p1_ack});
      end
      if (i < 4) tick();
    end
    mem_rdrdy = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rdrdy = 1'b0; mem_rdata = 32'h0;
    exp_rd1 = 32'h12345678;
    checks++;
    if (p1_ack !== 1'b1 || p1_rdata !== exp_rd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rd_ack: ack/rdata/busy got %b/%h/%b required 1/12345678/1",
               p1_ack, p1_rdata, busy);
    end
    p1_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || p1_ack !== 1'b0 || p1_rdata !== exp_rd1) begin
      failures++;
      $display("FAIL rd_after: busy/ack/rdata got %b/%b/%h required 0/0/12345678",
               busy, p1_ack, p1_rdata);
    end
  endtask

  task automatic test_alternate();
    bit ok;
    int exp_port;
    logic [31:0] d;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h1000;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      exp_port = k % 2;
      wait_raen(ok);
      checks++;
      if (!ok || mem_raddr !== (exp_port == 1 ? p1_addr : p0_addr)) begin
        failures++;
        $display("FAIL alt_grant%0d: raen/raddr got %b/%h required 1/%h", k, mem_raen,
                 mem_raddr, exp_port == 1 ? p1_addr : p0_addr);
      end
      mem_rardy = 1'b1;
      tick();
      mem_rardy = 1'b0;
      d = 32'hC0DE_0000 + k;
      mem_rdrdy = 1'b1; mem_rdata = d;
      tick();
      mem_rdrdy = 1'b0;
      if (exp_port == 1) exp_rd1 = d;
      else exp_rd0 = d;
      checks++;
      if ({p1_ack, p0_ack} !== (exp_port == 1 ? 2'b10 : 2'b01) ||
          p0_rdata !== exp_rd0 || p1_rdata !== exp_rd1) begin
        failures++;
        $display("FAIL alt_ack%0d: ack %b rdata0 %h rdata1 %h required port %0d %h %h", k,
                 {p1_ack, p0_ack}, p0_rdata, p1_rdata, exp_port, exp_rd0, exp_rd1);
      end
      if (exp_port == 1) p1_addr = p1_addr + 4;
      else p0_addr = p0_addr + 4;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h300; p0_wdata = 32'h11; p0_wmask = 4'h3;
    tick();
    mem_wardy = 1'b1; mem_wdrdy = 1'b1;
    tick();
    mem_wardy = 1'b0; mem_wdrdy = 1'b0;
    checks++;
    if ({mem_waen, mem_wden, busy} !== 3'b001) begin
      failures++;
      $display("FAIL mid_wrsp: waen,wden,busy got %b required 001", {mem_waen, mem_wden, busy});
    end
    reset = 1'b1;
    p0_req = 1'b0;
    tick();
    exp_rd0 = 32'h0; exp_rd1 = 32'h0;
    checks++;
    if ({mem_waen, mem_wden, mem_raen, mem_rden, p0_ack, p1_ack, busy} !== 7'b0 ||
        {mem_waddr, mem_raddr, mem_wdata, mem_wmask, p0_rdata, p1_rdata} !== '0) begin
      failures++;
      $display("FAIL mid_reset: ctrl %b waddr %h wdata %h rd0 %h rd1 %h required all 0",
               {mem_waen, mem_wden, mem_raen, mem_rden, p0_ack, p1_ack, busy},
               mem_waddr, mem_wdata, p0_rdata, p1_rdata);
    end
    reset = 1'b0;
    mem_wbvld = 1'b1;
    tick();
    mem_wbvld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({p0_ack, p1_ack} !== 2'b00) begin
        failures++;
        $display("FAIL stale_wbvld cyc%0d: acks got %b required 00", i, {p0_ack, p1_ack});
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        rq[2], we[2];
    logic [31:0] ad[2], wd[2];
    logic [3:0]  wm[2];
    logic [1:0]  prev_req;
    logic [31:0] resp;
    int          win, age, acks;
    bit          in_flight, wr_pend, rd_pend, last;
    rq[0] = 0; rq[1] = 0; we[0] = 0; we[1] = 0;
    ad[0] = 0; ad[1] = 0; wd[0] = 0; wd[1] = 0; wm[0] = 0; wm[1] = 0;
    in_flight = 0; wr_pend = 0; rd_pend = 0; last = 1; win = 0; age = 0; acks = 0;
    resp = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] && $urandom_range(0, 3) == 0) begin
          rq[p] = 1; we[p] = 1'($urandom_range(0, 1)); ad[p] = $urandom;
          wd[p] = $urandom; wm[p] = 4'($urandom);
        end
      end
      p0_req = rq[0]; p0_we = we[0]; p0_addr = ad[0]; p0_wdata = wd[0]; p0_wmask = wm[0];
      p1_req = rq[1]; p1_we = we[1]; p1_addr = ad[1]; p1_wdata = wd[1]; p1_wmask = wm[1];
      mem_wardy = 1'($urandom_range(0, 1));
      mem_wdrdy = 1'($urandom_range(0, 1));
      mem_rardy = 1'($urandom_range(0, 1));
      mem_wbvld = 1'b0; mem_rdrdy = 1'b0; mem_rdata = $urandom;
      if (wr_pend && !mem_waen && !mem_wden && $urandom_range(0, 2) == 0) begin
        mem_wbvld = 1'b1; wr_pend = 0;
      end
      if (rd_pend && !mem_raen && $urandom_range(0, 2) == 0) begin
        checks++;
        if (mem_rden !== 1'b1) begin
          failures++;
          $display("FAIL rnd_rden cyc%0d: rden got %b required 1", cyc, mem_rden);
        end
        mem_rdrdy = 1'b1; resp = mem_rdata; rd_pend = 0;
      end
      prev_req = {rq[1], rq[0]};
      tick();
      if (!in_flight && (mem_waen || mem_raen)) begin
        if (prev_req == 2'b11) win = last ? 0 : 1;
        else win = prev_req[1] ? 1 : 0;
        checks++;
        if (prev_req == 2'b00 || mem_waen !== we[win] || mem_raen !== !we[win] ||
            (we[win] && (mem_waddr !== ad[win] || mem_wdata !== wd[win] ||
                         mem_wmask !== wm[win])) ||
            (!we[win] && mem_raddr !== ad[win])) begin
          failures++;
          $display("FAIL rnd_issue cyc%0d: waen %b raen %b waddr %h raddr %h required port %0d we %b addr %h",
                   cyc, mem_waen, mem_raen, mem_waddr, mem_raddr, win, we[win], ad[win]);
        end
        in_flight = 1; wr_pend = we[win]; rd_pend = !we[win]; age = 0;
      end
      if (p0_ack || p1_ack) begin
        if (!we[win]) begin
          if (win == 1) exp_rd1 = resp;
          else exp_rd0 = resp;
        end
        checks++;
        if (!in_flight || {p1_ack, p0_ack} !== (win == 1 ? 2'b10 : 2'b01) ||
            p0_rdata !== exp_rd0 || p1_rdata !== exp_rd1) begin
          failures++;
          $display("FAIL rnd_ack cyc%0d: ack %b rd0 %h rd1 %h required port %0d %h %h",
                   cyc, {p1_ack, p0_ack}, p0_rdata, p1_rdata, win, exp_rd0, exp_rd1);
        end
        last = win[0]; in_flight = 0; rq[win] = 0; acks++;
      end
      if (in_flight) begin
        age++;
        if (age > 200) begin
          checks++;
          failures++;
          $display("FAIL rnd_stall cyc%0d: no ack within 200 cycles", cyc);
          break;
        end
      end
    end
    checks++;
    if (acks < 50) begin
      failures++;
      $display("FAIL rnd_progress: acks got %0d required at least 50", acks);
    end
    p0_req = 0; p1_req = 0; mem_wardy = 0; mem_wdrdy = 0; mem_rardy = 0;
    mem_wbvld = 0; mem_rdrdy = 0;
  endtask

  initial begin
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_wmask = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_wmask = 0;
    mem_ready = 0; mem_wardy = 0; mem_wdrdy = 0; mem_rardy = 0;
    mem_wbvld = 0; mem_rdrdy = 0; mem_rdata = 0;
    test_reset();
    test_mem_ready();
    test_write_split();
    test_read_p1();
    test_alternate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
